// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed program image as a byte stream,
// packs little-endian 32-bit words, writes them sequentially into the
// instruction memory, and releases the core from reset only after the
// complete image has arrived with a matching XOR checksum.
module imem_boot_loader #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_IMEM_ADDR_WIDTH = 9
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_rx_valid,
    input  logic [7:0]                   i_rx_data,
    output logic                         o_rx_ready,
    output logic                         o_imem_we,
    output logic [P_IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
    output logic [P_DATA_WIDTH-1:0]      o_imem_wdata,
    output logic                         o_core_rst_n,
    output logic                         o_busy,
    output logic                         o_err
);

    // The word counter needs one extra bit so a full-depth image
    // (N = 2^P_IMEM_ADDR_WIDTH) is representable without wrapping.
    localparam int          CNT_W     = P_IMEM_ADDR_WIDTH + 1;
    localparam logic [16:0] MAX_WORDS = 17'd1 << P_IMEM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               ready_en;   // low only until the first edge after reset
    logic               accepting;  // state is able to take a byte
    logic               rx_fire;    // a byte is consumed on this edge
    logic [7:0]         len_lo;
    logic [15:0]        len_full;
    logic               len_too_big;
    logic [CNT_W-1:0]   n_words;
    logic [CNT_W-1:0]   word_cnt;
    logic               last_word;
    logic [1:0]         lane;
    logic [7:0]         xor_acc;
    logic [23:0]        byte_sr;    // holds {b2,b1,b0} of the word being built

    assign accepting   = ready_en && (state inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM});
    assign o_rx_ready  = accepting;
    assign rx_fire     = i_rx_valid && accepting;
    assign len_full    = {i_rx_data, len_lo};
    assign len_too_big = {1'b0, len_full} > MAX_WORDS;
    assign last_word   = (word_cnt == (n_words - CNT_W'(1)));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_LEN0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case leaves one unassigned and infers a latch.
        state_nxt    = state;
        o_busy       = 1'b0;
        o_err        = 1'b0;
        o_core_rst_n = 1'b0;
        case (state)
            ST_LEN0: begin
                if (rx_fire) state_nxt = ST_LEN1;
            end
            ST_LEN1: begin
                o_busy = 1'b1;
                if (rx_fire) begin
                    if (len_too_big)          state_nxt = ST_ERR;
                    else if (len_full == '0)  state_nxt = ST_CSUM;
                    else                      state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                o_busy = 1'b1;
                if (rx_fire && (lane == 2'd3) && last_word) state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                o_busy = 1'b1;
                if (rx_fire) state_nxt = (i_rx_data == xor_acc) ? ST_RUN : ST_ERR;
            end
            ST_RUN: begin
                o_core_rst_n = 1'b1;
            end
            ST_ERR: begin
                o_err = 1'b1;
            end
            default: begin
                state_nxt = ST_ERR;
            end
        endcase
    end

    // Byte assembly, counters, checksum and the registered write port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en     <= 1'b0;
            len_lo       <= '0;
            n_words      <= '0;
            word_cnt     <= '0;
            lane         <= '0;
            xor_acc      <= '0;
            byte_sr      <= '0;
            o_imem_we    <= 1'b0;
            o_imem_waddr <= '0;
            o_imem_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values; the lane-3 write reads byte_sr and word_cnt
            // as they were before this edge's update.
            ready_en  <= 1'b1;
            o_imem_we <= 1'b0;
            if (rx_fire) begin
                case (state)
                    ST_LEN0: begin
                        len_lo <= i_rx_data;
                    end
                    ST_LEN1: begin
                        // Only meaningful when the length is in range.
                        n_words  <= len_full[CNT_W-1:0];
                        word_cnt <= '0;
                        lane     <= '0;
                        xor_acc  <= '0;
                    end
                    ST_DATA: begin
                        xor_acc <= xor_acc ^ i_rx_data;
                        lane    <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            o_imem_we    <= 1'b1;
                            o_imem_waddr <= word_cnt[P_IMEM_ADDR_WIDTH-1:0];
                            o_imem_wdata <= {i_rx_data, byte_sr};
                            word_cnt     <= word_cnt + CNT_W'(1);
                        end else begin
                            byte_sr <= {i_rx_data, byte_sr[23:8]};
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal, bad-checksum, length-error,
// full-depth, zero-length, bursty and mid-frame-reset loads.
module tb_imem_boot_loader;

    localparam int AW = 9;

    logic          clk;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          busy;
    logic          err;

    int n_assert = 0;
    int n_fail   = 0;

    // Write log filled by the monitor; tests look at entries from a base index.
    int          wr_cnt = 0;
    logic [31:0] wr_addr [0:4095];
    logic [31:0] wr_data [0:4095];

    localparam logic [31:0] W0 = 32'h0050_0093;
    localparam logic [31:0] W1 = 32'h00A0_0113;

    imem_boot_loader #(.P_DATA_WIDTH(32), .P_IMEM_ADDR_WIDTH(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_rx_ready   (rx_ready),
        .o_imem_we    (imem_we),
        .o_imem_waddr (imem_waddr),
        .o_imem_wdata (imem_wdata),
        .o_core_rst_n (core_rst_n),
        .o_busy       (busy),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every write strobe seen at a rising edge.
    always @(posedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr[wr_cnt] = 32'(imem_waddr);
            wr_data[wr_cnt] = imem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] wxor(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    task automatic do_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h5A;
    endtask

    // Sends one word and checks the write pulse appears right after lane 3.
    task automatic send_word(input logic [31:0] w, input int k, input bit gappy);
        for (int i = 0; i < 4; i++) begin
            if (gappy) idle($urandom_range(0, 2));
            send_byte(w[8*i +: 8]);
        end
        chk("we_after_lane3", 32'(imem_we), 32'd1);
        chk("waddr", 32'(imem_waddr), 32'(k));
        chk("wdata", imem_wdata, w);
        if (gappy) begin
            idle(1);
            chk("we_one_cycle", 32'(imem_we), 32'd0);
            chk("wdata_hold", imem_wdata, w);
        end
    endtask

    task automatic send_frame1(input bit gappy, input logic [7:0] csum);
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(W0, 0, gappy);
        send_word(W1, 1, gappy);
        if (gappy) idle(2);
        send_byte(csum);
    endtask

    task automatic chk_frame1_writes(input int base);
        chk("n_writes", 32'(wr_cnt - base), 32'd2);
        chk("wr0_addr", wr_addr[base],     32'd0);
        chk("wr0_data", wr_data[base],     W0);
        chk("wr1_addr", wr_addr[base + 1], 32'd1);
        chk("wr1_data", wr_data[base + 1], W1);
    endtask

    initial begin
        int          base;
        logic [7:0]  csum1;
        logic [7:0]  csum_big;
        logic [31:0] w;

        csum1    = wxor(W0) ^ wxor(W1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst_n    = 1'b1;

        // Reset values while reset is held.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we",       32'(imem_we),    32'd0);
        chk("rst_waddr",    32'(imem_waddr), 32'd0);
        chk("rst_wdata",    imem_wdata,      32'd0);
        chk("rst_core",     32'(core_rst_n), 32'd0);
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_err",      32'(err),        32'd0);
        do_reset();
        chk("ready_after_rst", 32'(rx_ready), 32'd1);

        // 1: normal load.
        base = wr_cnt;
        send_byte(8'h02);
        chk("t1_busy_len1", 32'(busy), 32'd1);
        send_byte(8'h00);
        send_word(W0, 0, 1'b0);
        send_word(W1, 1, 1'b0);
        chk("t1_core_before_csum", 32'(core_rst_n), 32'd0);
        send_byte(csum1);
        chk("t1_core_released", 32'(core_rst_n), 32'd1);
        chk("t1_err",   32'(err),      32'd0);
        chk("t1_busy",  32'(busy),     32'd0);
        chk("t1_ready", 32'(rx_ready), 32'd0);
        chk_frame1_writes(base);
        send_byte(8'hFF);
        chk("t1_run_hold", 32'(core_rst_n), 32'd1);
        chk("t1_no_extra_write", 32'(wr_cnt - base), 32'd2);

        // 2: bad checksum.
        do_reset();
        base = wr_cnt;
        send_frame1(1'b0, 8'h00);
        chk("t2_err",  32'(err),        32'd1);
        chk("t2_core", 32'(core_rst_n), 32'd0);
        chk("t2_ready", 32'(rx_ready),  32'd0);
        chk_frame1_writes(base);
        for (int i = 0; i < 4; i++) send_byte(8'h93);
        chk("t2_err_sticky", 32'(err), 32'd1);
        chk("t2_no_consume", 32'(wr_cnt - base), 32'd2);

        // 3: length one past the memory depth.
        do_reset();
        base = wr_cnt;
        send_byte(8'h01);
        send_byte(8'h02);
        chk("t3_err_on_len_hi", 32'(err),  32'd1);
        chk("t3_busy",          32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        chk("t3_no_writes", 32'(wr_cnt - base), 32'd0);
        chk("t3_core",      32'(core_rst_n),    32'd0);

        // 3b: length exactly equal to the depth fills every address.
        do_reset();
        base     = wr_cnt;
        csum_big = 8'h00;
        send_byte(8'h00);
        send_byte(8'h02);
        chk("t3b_err",  32'(err),  32'd0);
        chk("t3b_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 512; k++) begin
            w        = 32'hC0DE_0000 + 32'(k) * 32'h0001_0001;
            csum_big = csum_big ^ wxor(w);
            send_word(w, k, 1'b0);
        end
        chk("t3b_busy_csum", 32'(busy), 32'd1);
        send_byte(csum_big);
        chk("t3b_core",     32'(core_rst_n),       32'd1);
        chk("t3b_n_writes", 32'(wr_cnt - base),    32'd512);
        chk("t3b_first",    wr_addr[base],         32'd0);
        chk("t3b_last",     wr_addr[base + 511],   32'd511);
        chk("t3b_last_data", wr_data[base + 511],  32'hC0DE_0000 + 32'd511 * 32'h0001_0001);

        // 4: zero length.
        do_reset();
        base = wr_cnt;
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t4_busy_csum", 32'(busy), 32'd1);
        chk("t4_core_held", 32'(core_rst_n), 32'd0);
        send_byte(8'h00);
        chk("t4_core", 32'(core_rst_n), 32'd1);
        chk("t4_err",  32'(err),        32'd0);
        chk("t4_no_writes", 32'(wr_cnt - base), 32'd0);

        // 5: bursty valid.
        do_reset();
        base = wr_cnt;
        send_frame1(1'b1, csum1);
        chk("t5_core", 32'(core_rst_n), 32'd1);
        chk_frame1_writes(base);

        // 6: reset after six payload bytes, then reload.
        do_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(W0[8*i +: 8]);
        send_byte(W1[7:0]);
        send_byte(W1[15:8]);
        chk("t6_pre_wdata", imem_wdata, W0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_we",    32'(imem_we),    32'd0);
        chk("t6_rst_waddr", 32'(imem_waddr), 32'd0);
        chk("t6_rst_wdata", imem_wdata,      32'd0);
        chk("t6_rst_busy",  32'(busy),       32'd0);
        chk("t6_rst_core",  32'(core_rst_n), 32'd0);
        chk("t6_rst_err",   32'(err),        32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = wr_cnt;
        send_frame1(1'b0, csum1);
        chk("t6_core", 32'(core_rst_n), 32'd1);
        chk("t6_err",  32'(err),        32'd0);
        chk_frame1_writes(base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
